ldpc_enc_seq: RTL and testbench

LDPC_ENC_SEQ -- requirements
Module: ldpc_enc_seq

---
 rtl/ldpc_pkg.sv | 18 +
 rtl/ldpc_par_acc.sv | 29 ++
 rtl/ldpc_enc_seq.sv | 139 +++++++++++++
 tb/tb_ldpc_enc_seq.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ldpc_pkg.sv
// Shared constants for the LDPC encoder input/output sequencer.
// Optional build macro: LDPC_PARITY_ACC_EN (running-XOR accumulation of parity output).
package ldpc_pkg;

    localparam int unsigned K_INFO   = 4320;
    localparam int unsigned Z        = 360;
    localparam int unsigned N_GROUPS = 12;
    localparam int unsigned N_CODE   = K_INFO + Z;
    localparam int unsigned CNT_W    = 13;
    localparam int unsigned ADDR_W   = 9;

    // Sequencer state encoding
    localparam logic [1:0] S_INFO   = 2'd0;
    localparam logic [1:0] S_DRAIN  = 2'd1;
    localparam logic [1:0] S_PARITY = 2'd2;
    localparam logic [1:0] S_FLUSH  = 2'd3;

endpackage

// File: rtl/ldpc_par_acc.sv
// Running-XOR accumulator for the parity output stream.
// Instantiated only when LDPC_PARITY_ACC_EN is defined.
module ldpc_par_acc
    import ldpc_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    input  logic din,
    output logic dout
);

    logic acc_q;

    // Accumulate each forwarded parity bit; clear wins over enable
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_q <= 1'b0;
        end else if (clr) begin
            acc_q <= 1'b0;
        end else if (en) begin
            acc_q <= acc_q ^ din;
        end
    end

    assign dout = acc_q;

endmodule

// File: rtl/ldpc_enc_seq.sv
// LDPC encoder sequencer: feeds 4320 info bits to the encoder, then reads
// back 360 parity bits and emits a 4680-bit codeword stream.
// Optional build macro: LDPC_PARITY_ACC_EN (parity out_bit = enc_dout ^ previous parity bit).
module ldpc_enc_seq
    import ldpc_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic              in_bit,
    output logic              in_ready,
    output logic              enc_din_valid,
    output logic              enc_din,
    output logic [CNT_W-1:0]  enc_counter,
    output logic [ADDR_W-1:0] enc_out_addr,
    output logic              enc_check,
    input  logic              enc_dout,
    output logic              out_valid,
    output logic              out_bit,
    output logic              out_sof,
    output logic              out_eof,
    output logic              busy
);

    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  idx_q, idx_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              in_ready_q;
    logic              accept;
    logic              sys_valid_q, sys_bit_q, sys_sof_q;
    logic              par_valid_q, par_last_q;
    logic              par_bit;

    // in_ready_q is only ever high while in INFO
    assign accept = in_valid && in_ready_q;

    // State, index, parity address and ready registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_INFO;
            idx_q      <= '0;
            addr_q     <= '0;
            in_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            addr_q     <= addr_d;
            in_ready_q <= (state_d == S_INFO);
        end
    end

    // Next-state logic and encoder-side outputs
    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        addr_d        = addr_q;
        in_ready      = in_ready_q;
        enc_din_valid = accept;
        enc_din       = accept & in_bit;
        enc_counter   = idx_q;
        enc_out_addr  = '0;
        enc_check     = 1'b0;
        busy          = !((state_q == S_INFO) && (idx_q == '0));
        case (state_q)
            S_INFO: begin
                if (accept) begin
                    if (idx_q == CNT_W'(K_INFO - 1)) begin
                        idx_d   = '0;
                        state_d = S_DRAIN;
                    end else begin
                        idx_d = idx_q + CNT_W'(1);
                    end
                end
            end
            S_DRAIN: begin
                addr_d  = ADDR_W'(Z - 1);
                state_d = S_PARITY;
            end
            S_PARITY: begin
                enc_check    = 1'b1;
                enc_out_addr = addr_q;
                if (addr_q == '0) begin
                    state_d = S_FLUSH;
                end else begin
                    addr_d = addr_q - ADDR_W'(1);
                end
            end
            S_FLUSH: begin
                state_d = S_INFO;
            end
            default: begin
                state_d = S_INFO;
            end
        endcase
    end

    // Output-stream registers: systematic bits and parity-read phase tracking
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sys_valid_q <= 1'b0;
            sys_bit_q   <= 1'b0;
            sys_sof_q   <= 1'b0;
            par_valid_q <= 1'b0;
            par_last_q  <= 1'b0;
        end else begin
            sys_valid_q <= accept;
            sys_bit_q   <= accept & in_bit;
            sys_sof_q   <= accept && (idx_q == '0);
            par_valid_q <= (state_q == S_PARITY);
            par_last_q  <= (state_q == S_PARITY) && (addr_q == '0);
        end
    end

`ifdef LDPC_PARITY_ACC_EN
    logic acc_bit;

    ldpc_par_acc u_par_acc (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (state_q == S_DRAIN),
        .en    (par_valid_q),
        .din   (enc_dout),
        .dout  (acc_bit)
    );

    assign par_bit = enc_dout ^ acc_bit;
`else
    assign par_bit = enc_dout;
`endif

    // Encoder read data is already registered, so parity is forwarded directly
    always_comb begin
        out_valid = sys_valid_q | par_valid_q;
        out_bit   = par_valid_q ? par_bit : sys_bit_q;
        out_sof   = sys_sof_q;
        out_eof   = par_last_q;
    end

endmodule

// File: tb/tb_ldpc_enc_seq.sv
// Self-checking bench for ldpc_enc_seq with a behavioural encoder stub and a
// codeword scoreboard. Honours LDPC_PARITY_ACC_EN when computing expected parity.
module tb_ldpc_enc_seq;
    import ldpc_pkg::*;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid, in_bit, in_ready;
    logic              enc_din_valid, enc_din, enc_check, enc_dout;
    logic [CNT_W-1:0]  enc_counter;
    logic [ADDR_W-1:0] enc_out_addr;
    logic              out_valid, out_bit, out_sof, out_eof, busy;

    ldpc_enc_seq dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_bit        (in_bit),
        .in_ready      (in_ready),
        .enc_din_valid (enc_din_valid),
        .enc_din       (enc_din),
        .enc_counter   (enc_counter),
        .enc_out_addr  (enc_out_addr),
        .enc_check     (enc_check),
        .enc_dout      (enc_dout),
        .out_valid     (out_valid),
        .out_bit       (out_bit),
        .out_sof       (out_sof),
        .out_eof       (out_eof),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic b;
        logic sof;
        logic eof;
    } exp_t;

    exp_t exp_q[$];
    bit   cap[$];
    bit   cap_en = 1'b0;
    bit   frame[K_INFO];
    logic enc_par[Z];
    int   n_checks = 0;
    int   n_errors = 0;
    int   n_out = 0;
    int   n_eof = 0;
    bit   sys_exp = 1'b0;

    // Toy quasi-cyclic code: each info bit touches two parity positions
    function automatic int p1(input int i);
        return i % 360;
    endfunction

    function automatic int p2(input int i);
        return ((i / 360) * 53 + i * 7 + 11) % 360;
    endfunction

    // Encoder stub: accumulates parity from the din stream, 1-cycle registered read
    always @(posedge clk) begin
        if (!rst_n) begin
            foreach (enc_par[j]) enc_par[j] = 1'b0;
            enc_dout <= 1'b0;
        end else begin
            enc_dout <= (enc_check === 1'b1) ? enc_par[enc_out_addr] : 1'b0;
            if (enc_din_valid === 1'b1) begin
                if (enc_counter == '0) foreach (enc_par[j]) enc_par[j] = 1'b0;
                if (enc_din === 1'b1) begin
                    enc_par[p1(int'(enc_counter))] = ~enc_par[p1(int'(enc_counter))];
                    enc_par[p2(int'(enc_counter))] = ~enc_par[p2(int'(enc_counter))];
                end
            end
        end
    end

    // Acceptance seen at a clock edge must produce out_valid in the next cycle
    always @(posedge clk) sys_exp <= rst_n && (in_valid === 1'b1) && (in_ready === 1'b1);

    // Output monitor / scoreboard
    always @(negedge clk) begin
        if (out_valid === 1'b1) begin
            exp_t e;
            n_out++;
            if (out_eof === 1'b1) n_eof++;
            if (cap_en) cap.push_back(out_bit);
            n_checks++;
            if (exp_q.size() == 0) begin
                n_errors++;
                if (n_errors < 30) $display("FAIL unexpected_output got bit=%b with empty queue", out_bit);
            end else begin
                e = exp_q.pop_front();
                if ({out_bit, out_sof, out_eof} !== {e.b, e.sof, e.eof}) begin
                    n_errors++;
                    if (n_errors < 30)
                        $display("FAIL codeword_bit out#%0d got {bit,sof,eof}=%b%b%b expected %b%b%b",
                                 n_out, out_bit, out_sof, out_eof, e.b, e.sof, e.eof);
                end
            end
        end
        if (sys_exp) begin
            n_checks++;
            if (out_valid !== 1'b1) begin
                n_errors++;
                if (n_errors < 30) $display("FAIL sys_latency got out_valid=%b expected 1", out_valid);
            end
        end
    end

    task automatic fail_int(input string name, input int got, input int want);
        $display("FAIL %s got %0d expected %0d", name, got, want);
    endtask

    task automatic randomize_frame();
        foreach (frame[i]) frame[i] = 1'($urandom_range(1));
    endtask

    // Drive n_bits of frame[]; push expected systematic bits, and parity if the frame completes
    task automatic drive_frame(input int n_bits, input int gap_pct);
        bit exp_par[Z];
        bit acc;
        for (int i = 0; i < n_bits; i++) begin
            int waits;
            if (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
                in_valid = 1'b0;
                in_bit   = 1'($urandom_range(1));
                repeat ($urandom_range(1, 2)) begin @(posedge clk); #1; end
            end
            in_valid = 1'b1;
            in_bit   = frame[i];
            exp_q.push_back('{b: frame[i], sof: (i == 0), eof: 1'b0});
            waits = 0;
            while (in_ready !== 1'b1) begin
                @(posedge clk); #1;
                waits++;
                if (waits > 1000) begin
                    n_checks++; n_errors++;
                    fail_int("in_ready_timeout", waits, 0);
                    in_valid = 1'b0;
                    return;
                end
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        in_bit   = 1'b0;
        if (n_bits == int'(K_INFO)) begin
            foreach (exp_par[j]) exp_par[j] = 1'b0;
            for (int i = 0; i < int'(K_INFO); i++) begin
                if (frame[i]) begin
                    exp_par[p1(i)] ^= 1'b1;
                    exp_par[p2(i)] ^= 1'b1;
                end
            end
            acc = 1'b0;
            for (int a = int'(Z) - 1; a >= 0; a--) begin
                bit b;
                b = exp_par[a];
`ifdef LDPC_PARITY_ACC_EN
                acc = acc ^ b;
                b   = acc;
`endif
                exp_q.push_back('{b: b, sof: 1'b0, eof: (a == 0)});
            end
        end
    endtask

    // Observe the window while in_ready is low after a frame
    task automatic measure_gap(output int low, output int ovc, output int chk,
                               output int first_addr, output int last_addr, output int busy_low);
        low = 0; ovc = 0; chk = 0; first_addr = -1; last_addr = -1; busy_low = 0;
        while (in_ready !== 1'b1 && low < 1000) begin
            low++;
            if (out_valid === 1'b1) ovc++;
            if (busy !== 1'b1) busy_low++;
            if (enc_check === 1'b1) begin
                if (chk == 0) first_addr = int'(enc_out_addr);
                last_addr = int'(enc_out_addr);
                chk++;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic check_gap(input string tag);
        int low, ovc, chk, fa, la, bl;
        measure_gap(low, ovc, chk, fa, la, bl);
        n_checks++; if (low !== 362) begin n_errors++; fail_int({tag, "_ready_low"}, low, 362); end
        n_checks++; if (ovc !== 361) begin n_errors++; fail_int({tag, "_window_out_valid"}, ovc, 361); end
        n_checks++; if (chk !== 360) begin n_errors++; fail_int({tag, "_check_cycles"}, chk, 360); end
        n_checks++; if (fa !== 359) begin n_errors++; fail_int({tag, "_first_addr"}, fa, 359); end
        n_checks++; if (la !== 0) begin n_errors++; fail_int({tag, "_last_addr"}, la, 0); end
        n_checks++; if (bl !== 0) begin n_errors++; fail_int({tag, "_busy_drop"}, bl, 0); end
    endtask

    task automatic wait_drain(input string tag);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 500) begin @(posedge clk); #1; n++; end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            fail_int({tag, "_drain_left"}, exp_q.size(), 0);
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b1; in_bit = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (in_ready !== 1'b0) begin n_errors++; fail_int("rst_in_ready", in_ready, 0); end
        n_checks++; if (enc_din_valid !== 1'b0) begin n_errors++; fail_int("rst_din_valid", enc_din_valid, 0); end
        n_checks++; if (enc_din !== 1'b0) begin n_errors++; fail_int("rst_din", enc_din, 0); end
        n_checks++; if (enc_counter !== '0) begin n_errors++; fail_int("rst_counter", enc_counter, 0); end
        n_checks++; if (enc_out_addr !== '0) begin n_errors++; fail_int("rst_addr", enc_out_addr, 0); end
        n_checks++; if (enc_check !== 1'b0) begin n_errors++; fail_int("rst_check", enc_check, 0); end
        n_checks++; if ({out_valid, out_bit, out_sof, out_eof} !== 4'b0) begin n_errors++; fail_int("rst_out", {out_valid, out_bit, out_sof, out_eof}, 0); end
        n_checks++; if (busy !== 1'b0) begin n_errors++; fail_int("rst_busy", busy, 0); end
        in_valid = 1'b0; in_bit = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_checks++; if (in_ready !== 1'b1) begin n_errors++; fail_int("rst_ready_rise", in_ready, 1); end
    endtask

    task automatic test_zero_frame();
        int o0, e0;
        foreach (frame[i]) frame[i] = 1'b0;
        o0 = n_out; e0 = n_eof;
        drive_frame(K_INFO, 0);
        check_gap("zero");
        wait_drain("zero");
        n_checks++; if (n_out - o0 !== 4680) begin n_errors++; fail_int("zero_len", n_out - o0, 4680); end
        n_checks++; if (n_eof - e0 !== 1) begin n_errors++; fail_int("zero_eof", n_eof - e0, 1); end
        n_checks++; if (busy !== 1'b0) begin n_errors++; fail_int("zero_idle_busy", busy, 0); end
    endtask

    task automatic test_single_one();
        int o0;
        foreach (frame[i]) frame[i] = 1'b0;
        frame[0] = 1'b1;
        o0 = n_out;
        drive_frame(K_INFO, 0);
        check_gap("single");
        wait_drain("single");
        n_checks++; if (n_out - o0 !== 4680) begin n_errors++; fail_int("single_len", n_out - o0, 4680); end
    endtask

    task automatic test_gaps();
        bit ref_cw[$];
        int diffs;
        randomize_frame();
        cap.delete(); cap_en = 1'b1;
        drive_frame(K_INFO, 0);
        check_gap("contig");
        wait_drain("contig");
        ref_cw = cap;
        cap.delete();
        drive_frame(K_INFO, 30);
        check_gap("gapped");
        wait_drain("gapped");
        cap_en = 1'b0;
        diffs = 0;
        if (cap.size() != ref_cw.size()) diffs = 99999;
        else foreach (cap[i]) if (cap[i] != ref_cw[i]) diffs++;
        n_checks++; if (diffs !== 0) begin n_errors++; fail_int("gap_vs_contig_diffs", diffs, 0); end
    endtask

    task automatic test_reset_mid();
        int e0;
        randomize_frame();
        e0 = n_eof;
        drive_frame(2000, 0);
        rst_n = 1'b0;
        @(posedge clk); #1;
        n_checks++; if (out_valid !== 1'b0) begin n_errors++; fail_int("mid_rst_out_valid", out_valid, 0); end
        n_checks++; if (in_ready !== 1'b0) begin n_errors++; fail_int("mid_rst_in_ready", in_ready, 0); end
        n_checks++; if (enc_counter !== '0) begin n_errors++; fail_int("mid_rst_counter", enc_counter, 0); end
        n_checks++; if (exp_q.size() !== 0) begin n_errors++; fail_int("mid_rst_pending", exp_q.size(), 0); end
        exp_q.delete();
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_checks++; if (in_ready !== 1'b1) begin n_errors++; fail_int("mid_rst_ready_rise", in_ready, 1); end
        randomize_frame();
        drive_frame(K_INFO, 0);
        check_gap("after_rst");
        wait_drain("after_rst");
        n_checks++; if (n_eof - e0 !== 1) begin n_errors++; fail_int("mid_rst_eof", n_eof - e0, 1); end
    endtask

    task automatic test_back_to_back();
        int o0, e0;
        o0 = n_out; e0 = n_eof;
        randomize_frame();
        drive_frame(K_INFO, 0);
        check_gap("b2b_a");
        randomize_frame();
        drive_frame(K_INFO, 0);
        check_gap("b2b_b");
        wait_drain("b2b");
        n_checks++; if (n_out - o0 !== 9360) begin n_errors++; fail_int("b2b_len", n_out - o0, 9360); end
        n_checks++; if (n_eof - e0 !== 2) begin n_errors++; fail_int("b2b_eof", n_eof - e0, 2); end
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_bit = 1'b0;
        test_reset();
        test_zero_frame();
        test_single_one();
        test_gaps();
        test_reset_mid();
        test_back_to_back();
        repeat (4) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
